// File: rtl/full_subtractor.sv
// Ripple-borrow WIDTH-bit subtractor with a 1-cycle registered result copy.
// Optional borrow counter enabled by FULL_SUBTRACTOR_STATS_EN.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic [WIDTH-1:0] D_q,
  output logic             Bout_q,
  output logic             out_valid
`ifdef FULL_SUBTRACTOR_STATS_EN
  ,
  output logic [15:0]      borrow_cnt
`endif
);

  logic [WIDTH:0] b;

  assign b[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign D[i]   = A[i] ^ B[i] ^ b[i];
    assign b[i+1] = (~A[i] & B[i])
                  | (~(A[i] ^ B[i]) & b[i]);
  end

  assign Bout = b[WIDTH];

  // D_q/Bout_q hold when idle; only out_valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_q       <= '0;
      Bout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      D_q       <= D;
      Bout_q    <= Bout;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef FULL_SUBTRACTOR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_cnt <= '0;
    end else if (in_valid && Bout && (borrow_cnt != 16'hFFFF)) begin
      borrow_cnt <= borrow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Randomized self-checking bench for full_subtractor (WIDTH=1 and WIDTH=8).
// Exercises the counter too when FULL_SUBTRACTOR_STATS_EN is defined.
module tb_full_subtractor;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, bin1, iv1;
  logic       d1, bout1, dq1, bq1, ov1;

  logic [7:0] a8, b8;
  logic       bin8, iv8;
  logic [7:0] d8, dq8;
  logic       bout8, bq8, ov8;

`ifdef FULL_SUBTRACTOR_STATS_EN
  logic [15:0] cnt1, cnt8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .A(a1), .B(b1), .Bin(bin1), .in_valid(iv1),
    .D(d1), .Bout(bout1),
    .D_q(dq1), .Bout_q(bq1), .out_valid(ov1)
`ifdef FULL_SUBTRACTOR_STATS_EN
    , .borrow_cnt(cnt1)
`endif
  );

  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .A(a8), .B(b8), .Bin(bin8), .in_valid(iv8),
    .D(d8), .Bout(bout8),
    .D_q(dq8), .Bout_q(bq8), .out_valid(ov8)
`ifdef FULL_SUBTRACTOR_STATS_EN
    , .borrow_cnt(cnt8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {Bout,D} from plain integer subtraction mod 2^9
  function automatic logic [8:0] ref_sub(input int a, input int b,
                                         input int bin);
    int r;
    r = a - b - bin;
    return r[8:0];
  endfunction

  logic [1:0] tbl [8];
  logic [8:0] r;
  logic [7:0] m_dq;
  logic       m_bq, m_ov;
  int         m_cnt;

  initial begin
    tbl[0] = 2'b00; tbl[1] = 2'b11;
    tbl[2] = 2'b11; tbl[3] = 2'b01;
    tbl[4] = 2'b10; tbl[5] = 2'b00;
    tbl[6] = 2'b00; tbl[7] = 2'b11;

    rst_n = 1'b0;
    {a1, b1, bin1, iv1} = '0;
    a8 = '0; b8 = '0; bin8 = 1'b0; iv8 = 1'b0;
    m_dq = '0; m_bq = 1'b0; m_ov = 1'b0; m_cnt = 0;
    #1;
    check("rst_dq", dq8, 0);
    check("rst_bq", bq8, 0);
    check("rst_ov", ov8, 0);
`ifdef FULL_SUBTRACTOR_STATS_EN
    check("rst_cnt", cnt8, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, bin1} = v;
      #1;
      check($sformatf("w1_%0d", i), {d1, bout1}, tbl[i]);
    end

    @(negedge clk) rst_n = 1'b1;

    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk) #1;
    check("reg_dq", dq8, 8'h02);
    check("reg_bq", bq8, 0);
    check("reg_ov", ov8, 1);
    @(negedge clk) iv8 = 1'b0;
    @(posedge clk) #1;
    check("hold_dq", dq8, 8'h02);
    check("hold_ov", ov8, 0);
    m_dq = 8'h02; m_bq = 1'b0; m_ov = 1'b0;

    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
    #1;
    check("wrap_d", d8, 8'h00);
    check("wrap_b", bout8, 1);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    #1;
    check("max_d", d8, 8'hFF);
    check("max_b", bout8, 0);

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      bin8 = 1'($urandom);
      iv8  = ($urandom_range(3) != 0);
      if (n % 4 == 0) a8 = 8'($urandom_range(3));
      r = ref_sub(int'(a8), int'(b8), int'(bin8));
      #1;
      check("rnd_d", d8, r[7:0]);
      check("rnd_b", bout8, r[8]);
      if (iv8) begin
        m_dq = r[7:0]; m_bq = r[8]; m_ov = 1'b1;
        if (r[8] && m_cnt < 65535) m_cnt++;
      end else begin
        m_ov = 1'b0;
      end
      @(posedge clk) #1;
      check("rnd_dq", dq8, m_dq);
      check("rnd_bq", bq8, m_bq);
      check("rnd_ov", ov8, m_ov);
`ifdef FULL_SUBTRACTOR_STATS_EN
      check("rnd_cnt", cnt8, m_cnt);
`endif
    end

    @(negedge clk);
    a8 = 8'h10; b8 = 8'h30; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk) #1;
    check("pre_ov", ov8, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_dq", dq8, 0);
    check("arst_bq", bq8, 0);
    check("arst_ov", ov8, 0);
`ifdef FULL_SUBTRACTOR_STATS_EN
    check("arst_cnt", cnt8, 0);
`endif
    a8 = 8'h42; b8 = 8'h11; bin8 = 1'b1;
    r = ref_sub(int'(a8), int'(b8), int'(bin8));
    #1;
    check("arst_d", d8, r[7:0]);
    check("arst_b", bout8, r[8]);
    iv8 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("post_ov", ov8, 0);
    check("post_dq", dq8, 0);

`ifdef FULL_SUBTRACTOR_STATS_EN
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0; iv8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cnt3", cnt8, 3);
    repeat (65532) @(posedge clk);
    #1;
    check("cnt_full", cnt8, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    check("cnt_sat", cnt8, 16'hFFFF);
    @(negedge clk) iv8 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
